// File: rtl/saes64_lockstep_checker.sv
// Lockstep result checker: collects one result per lane for each issued operation,
// compares every lane against lane 0, flags arrival skew and timeouts, and keeps stats.
module saes64_lockstep_checker #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned LANES   = 2,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    g_clk,
    input  logic                    g_reset,
    input  logic                    valid,
    input  logic [LANES-1:0]        lane_ready,
    input  logic [LANES*XLEN-1:0]   lane_rd,
    input  logic                    clear,
    output logic                    busy,
    output logic                    done,
    output logic                    match,
    output logic                    skew_fail,
    output logic                    timeout,
    output logic [LANES-1:0]        mismatch_mask,
    output logic [CNT_W-1:0]        op_count,
    output logic [CNT_W-1:0]        fail_count,
    output logic                    sticky_fail
);

    // TIMEOUT is at most 255, so the COLLECT cycle counter never needs more than 8 bits
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t            state;
    logic [LANES-1:0]  captured;
    logic [XLEN-1:0]   data_q    [LANES];
    logic [TW-1:0]     arrival_q [LANES];
    logic [TW-1:0]     cyc;

    logic [LANES-1:0]  cap_n;
    logic [XLEN-1:0]   data_n    [LANES];
    logic [TW-1:0]     arr_n     [LANES];
    logic              all_cap;
    logic              finish;
    logic [LANES-1:0]  mask_n;
    logic              skew_n;
    logic              match_n;
    logic              fail_n;

    // Capture state as it will look after this cycle, and the verdict it implies
    always_comb begin
        cap_n   = captured;
        mask_n  = '0;
        skew_n  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            data_n[i] = data_q[i];
            arr_n[i]  = arrival_q[i];
            if (lane_ready[i] && !captured[i]) begin
                cap_n[i]  = 1'b1;
                data_n[i] = lane_rd[i*XLEN +: XLEN];
                arr_n[i]  = cyc;
            end
        end
        all_cap   = &cap_n;
        finish    = all_cap || (cyc == TW'(TIMEOUT - 1));
        mask_n[0] = !cap_n[0];
        for (int i = 1; i < LANES; i++) begin
            mask_n[i] = !cap_n[i] || (data_n[i] != data_n[0]);
        end
        for (int i = 1; i < LANES; i++) begin
            if (arr_n[i] != arr_n[0]) begin
                skew_n = 1'b1;
            end
        end
        skew_n  = skew_n && all_cap;
        match_n = all_cap && (mask_n == '0);
        fail_n  = !match_n || skew_n;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state         <= IDLE;
            captured      <= '0;
            cyc           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            match         <= 1'b0;
            skew_fail     <= 1'b0;
            timeout       <= 1'b0;
            mismatch_mask <= '0;
            op_count      <= '0;
            fail_count    <= '0;
            sticky_fail   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                data_q[i]    <= '0;
                arrival_q[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        state    <= COLLECT;
                        busy     <= 1'b1;
                        captured <= '0;
                        cyc      <= '0;
                        for (int i = 0; i < LANES; i++) begin
                            data_q[i]    <= '0;
                            arrival_q[i] <= '0;
                        end
                    end
                end
                COLLECT: begin
                    captured <= cap_n;
                    cyc      <= cyc + TW'(1);
                    for (int i = 0; i < LANES; i++) begin
                        data_q[i]    <= data_n[i];
                        arrival_q[i] <= arr_n[i];
                    end
                    // Verdicts and statistics become visible together with done
                    if (finish) begin
                        state         <= REPORT;
                        done          <= 1'b1;
                        match         <= match_n;
                        skew_fail     <= skew_n;
                        timeout       <= !all_cap;
                        mismatch_mask <= mask_n;
                        if (op_count != '1) begin
                            op_count <= op_count + CNT_W'(1);
                        end
                        if (fail_n) begin
                            sticky_fail <= 1'b1;
                            if (fail_count != '1) begin
                                fail_count <= fail_count + CNT_W'(1);
                            end
                        end
                    end
                end
                REPORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Clear overrides any statistics update made in the same cycle
            if (clear) begin
                op_count    <= '0;
                fail_count  <= '0;
                sticky_fail <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_saes64_lockstep_checker.sv
// Bench for saes64_lockstep_checker: directed and randomized operations scored
// against an operation-level model (arrival schedule -> latency and verdict).
module tb_saes64_lockstep_checker;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned LANES   = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int          NEVER   = 99;
    localparam int          CMAX    = (1 << CNT_W) - 1;

    logic                  g_clk = 1'b0;
    logic                  g_reset;
    logic                  valid;
    logic [LANES-1:0]      lane_ready;
    logic [LANES*XLEN-1:0] lane_rd;
    logic                  clear;
    logic                  busy, done, match, skew_fail, timeout, sticky_fail;
    logic [LANES-1:0]      mismatch_mask;
    logic [CNT_W-1:0]      op_count, fail_count;

    saes64_lockstep_checker #(
        .XLEN(XLEN), .LANES(LANES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .g_clk(g_clk), .g_reset(g_reset), .valid(valid), .lane_ready(lane_ready),
        .lane_rd(lane_rd), .clear(clear), .busy(busy), .done(done), .match(match),
        .skew_fail(skew_fail), .timeout(timeout), .mismatch_mask(mismatch_mask),
        .op_count(op_count), .fail_count(fail_count), .sticky_fail(sticky_fail)
    );

    always #5 g_clk = ~g_clk;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int               m_ops = 0, m_fails = 0;
    bit               m_sticky = 0;
    bit               m_match = 0, m_skew = 0, m_to = 0;
    logic [LANES-1:0] m_mask = '0;

    // per-operation schedule: COLLECT index at which each lane strobes, and its value
    int              arr [LANES];
    logic [XLEN-1:0] val [LANES];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk_stats(input string tag);
        chk({tag, "_op_count"}, 64'(op_count), 64'(m_ops));
        chk({tag, "_fail_count"}, 64'(fail_count), 64'(m_fails));
        chk({tag, "_sticky"}, 64'(sticky_fail), 64'(m_sticky));
    endtask

    task automatic chk_verdict(input string tag);
        chk({tag, "_match"}, 64'(match), 64'(m_match));
        chk({tag, "_skew"}, 64'(skew_fail), 64'(m_skew));
        chk({tag, "_timeout"}, 64'(timeout), 64'(m_to));
        chk({tag, "_mask"}, 64'(mismatch_mask), 64'(m_mask));
    endtask

    // Issue one operation following arr/val; optionally inject ignored noise and a final clear
    task automatic run_op(input string tag, input bit noise, input bit do_clear);
        bit all_in;
        int mx, exp_len, got;
        all_in = 1;
        mx = 0;
        for (int i = 0; i < LANES; i++) begin
            if (arr[i] >= int'(TIMEOUT)) all_in = 0;
            else if (arr[i] > mx) mx = arr[i];
        end
        exp_len = all_in ? mx + 1 : int'(TIMEOUT);
        m_to = !all_in;
        m_mask = '0;
        m_mask[0] = (arr[0] >= int'(TIMEOUT));
        m_skew = 0;
        for (int i = 1; i < LANES; i++) begin
            m_mask[i] = (arr[i] >= int'(TIMEOUT)) || (val[i] != val[0]);
            if (arr[i] != arr[0]) m_skew = all_in;
        end
        m_match = all_in && (m_mask == '0);
        if (do_clear) begin
            m_ops = 0; m_fails = 0; m_sticky = 0;
        end else begin
            if (m_ops < CMAX) m_ops++;
            if (!m_match || m_skew) begin
                m_sticky = 1;
                if (m_fails < CMAX) m_fails++;
            end
        end

        @(negedge g_clk);
        valid = 1'b1;
        clear = 1'b0;
        lane_ready = noise ? LANES'($urandom) : '0;
        lane_rd = {rnd64(), rnd64()};
        @(posedge g_clk); #1;
        chk({tag, "_busy_start"}, 64'(busy), 64'd1);

        got = -1;
        for (int k = 0; k < int'(TIMEOUT) + 4 && got < 0; k++) begin
            @(negedge g_clk);
            valid = noise ? 1'($urandom) : 1'b0;
            clear = do_clear && (k == exp_len - 1);
            for (int i = 0; i < LANES; i++) begin
                lane_rd[i*XLEN +: XLEN] = rnd64();
                lane_ready[i] = 1'b0;
                if (arr[i] == k) begin
                    lane_ready[i] = 1'b1;
                    lane_rd[i*XLEN +: XLEN] = val[i];
                end else if (noise && arr[i] < k) begin
                    lane_ready[i] = 1'($urandom);
                end
            end
            @(posedge g_clk); #1;
            if (done === 1'b1) got = k;
        end
        chk({tag, "_latency"}, 64'(got), 64'(exp_len - 1));
        chk({tag, "_busy_report"}, 64'(busy), 64'd1);
        chk_verdict(tag);
        chk_stats(tag);

        // REPORT cycle: any valid here must be dropped
        @(negedge g_clk);
        valid = noise ? 1'($urandom) : 1'b0;
        lane_ready = noise ? LANES'($urandom) : '0;
        clear = do_clear;
        @(posedge g_clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk_verdict({tag, "_hold"});
        chk_stats({tag, "_after"});
        @(negedge g_clk);
        valid = 1'b0;
        lane_ready = '0;
        clear = 1'b0;
    endtask

    initial begin
        g_reset = 1'b1;
        valid = 1'b0;
        clear = 1'b0;
        lane_ready = '0;
        lane_rd = '0;
        repeat (3) @(posedge g_clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_verdict("rst");
        chk_stats("rst");
        @(negedge g_clk);
        g_reset = 1'b0;

        // nominal match, both lanes ready two cycles after valid
        arr[0] = 1; arr[1] = 1;
        val[0] = 64'h0123456789ABCDEF; val[1] = 64'h0123456789ABCDEF;
        run_op("match", 0, 0);

        // single-bit data difference on lane 1
        val[1] = 64'h0123456789ABCDEE;
        run_op("mismatch", 0, 0);

        // equal data, lane 1 one cycle late
        arr[1] = 2; val[1] = val[0];
        run_op("skew", 0, 0);

        // lane 1 never answers
        arr[1] = NEVER;
        run_op("timeout", 0, 0);

        // lane 1 answers in the very last COLLECT cycle
        arr[0] = 0; arr[1] = int'(TIMEOUT) - 1;
        run_op("last_cycle", 1, 0);

        // clear in IDLE zeroes statistics but keeps verdicts
        @(negedge g_clk);
        clear = 1'b1;
        @(posedge g_clk); #1;
        m_ops = 0; m_fails = 0; m_sticky = 0;
        chk_stats("clr_idle");
        chk_verdict("clr_idle");
        @(negedge g_clk);
        clear = 1'b0;

        // randomized operations with repeats and ignored strobes
        for (int n = 0; n < 60; n++) begin
            int r;
            arr[0] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT - 1))
                                                 : int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (r < 5)      arr[1] = arr[0];
            else if (r < 8) arr[1] = int'($urandom_range(0, TIMEOUT - 1));
            else            arr[1] = NEVER;
            val[0] = rnd64();
            val[1] = ($urandom_range(0, 3) == 0) ? (val[0] ^ (64'd1 << $urandom_range(0, 63)))
                                                 : val[0];
            run_op("rand", 1, 0);
        end

        // reset in the middle of COLLECT discards the operation
        @(negedge g_clk);
        valid = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        valid = 1'b0;
        lane_ready = 2'b01;
        lane_rd = {rnd64(), rnd64()};
        @(negedge g_clk);
        lane_ready = '0;
        g_reset = 1'b1;
        valid = 1'b1;
        @(posedge g_clk); #1;
        m_ops = 0; m_fails = 0; m_sticky = 0;
        m_match = 0; m_skew = 0; m_to = 0; m_mask = '0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk_verdict("midrst");
        chk_stats("midrst");
        @(negedge g_clk);
        g_reset = 1'b0;
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge g_clk); #1;
            chk("midrst_no_done", 64'(done), 64'd0);
            chk("midrst_idle", 64'(busy), 64'd0);
        end
        arr[0] = 2; arr[1] = 2; val[0] = rnd64(); val[1] = val[0];
        run_op("post_rst", 0, 0);

        // drive fail_count to saturation
        for (int n = 0; n < CMAX + 5; n++) begin
            arr[0] = 0; arr[1] = 0;
            val[0] = rnd64(); val[1] = ~val[0];
            run_op("sat", 0, 0);
        end
        chk("sat_fail_count", 64'(fail_count), 64'(CMAX));

        // clear coincident with the completing failing operation
        arr[0] = 0; arr[1] = 1; val[0] = rnd64(); val[1] = val[0] ^ 64'h8;
        run_op("clr_report", 0, 1);

        arr[0] = 0; arr[1] = 0; val[0] = rnd64(); val[1] = val[0];
        run_op("final", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/saes64_lockstep_checker.md
SAES64_LOCKSTEP_CHECKER -- requirements
Module: saes64_lockstep_checker

Interface
REQ-001 SHALL have parameter XLEN, default 64, result width per lane.
REQ-002 SHALL have parameter LANES, default 2, number of compared instances (legal 2..8).
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum COLLECT cycles per operation (legal 2..255).
REQ-004 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-005 g_clk  input  1  sole clock; all state changes on rising edge.
REQ-006 g_reset  input  1  reset, synchronous, active-high.
REQ-007 valid  input  1  operation issued to all lanes this cycle.
REQ-008 lane_ready  input  LANES  per-lane result-ready strobe.
REQ-009 lane_rd  input  LANES*XLEN  per-lane result; lane i at bits [i*XLEN +: XLEN].
REQ-010 clear  input  1  zero statistics counters and sticky_fail.
REQ-011 busy  output  1  high in COLLECT and REPORT.
REQ-012 done  output  1  one-cycle pulse per completed comparison.
REQ-013 match, skew_fail, timeout  output  1 each  verdict of last comparison.
REQ-014 mismatch_mask  output  LANES  per-lane failure of last comparison.
REQ-015 op_count, fail_count  output  CNT_W each  saturating statistics.
REQ-016 sticky_fail  output  1  set on any failed comparison since reset/clear.

Function
REQ-017 FSM states IDLE, COLLECT, REPORT; reset state IDLE.
REQ-018 IDLE: valid=1 -> COLLECT next cycle; captured mask, arrival registers and cycle counter zeroed; lane_ready ignored in IDLE.
REQ-019 COLLECT: cycle counter starts at 0 and increments each COLLECT cycle; lane i with lane_ready[i]=1 and not yet captured -> capture lane_rd slice, set captured[i], record current counter value as arrival[i].
REQ-020 Repeat lane_ready from an already-captured lane SHALL be ignored (first value kept).
REQ-021 All lanes captured (including this cycle's captures) -> REPORT next cycle.
REQ-022 Counter == TIMEOUT-1 with any lane uncaptured -> REPORT next cycle with timeout=1; COLLECT never exceeds TIMEOUT cycles.
REQ-023 REPORT lasts exactly one cycle, then IDLE; done=1 only in REPORT.
REQ-024 valid while busy SHALL be ignored; no queuing.
REQ-025 mismatch_mask[i], i>0: 1 if lane i uncaptured or captured value != lane 0 value; bit 0: 1 only if lane 0 uncaptured.
REQ-026 skew_fail=1 iff timeout=0 and arrival values of all lanes not identical.
REQ-027 match=1 iff timeout=0 and mismatch_mask all zero (skew does not affect match).
REQ-028 match, skew_fail, timeout, mismatch_mask update on entry to REPORT and hold until next REPORT.
REQ-029 REPORT: op_count +1; fail_count +1 if match=0 or skew_fail=1; both saturate at all-ones; sticky_fail set on same condition.
REQ-030 clear is synchronous; when coincident with REPORT, clear wins (counters 0, sticky_fail 0); clear does not affect FSM or verdicts.

Reset
REQ-031 g_reset=1 at any state, including mid-COLLECT, SHALL force IDLE next cycle and zero all outputs, counters, captured state; in-flight operation discarded, no done.
REQ-032 g_reset has priority over valid, lane_ready and clear.

Verification
REQ-033 LANES=2: valid at c0; both ready at c2, rd=0x0123456789ABCDEF -> done at c3, match=1, mismatch_mask=2'b00, skew_fail=0, op_count=1.
REQ-034 Same but lane1 rd=0x0123456789ABCDEE -> match=0, mismatch_mask=2'b10, fail_count=1, sticky_fail=1.
REQ-035 Equal data, lane0 ready c2, lane1 ready c3 -> done c4, match=1, skew_fail=1, fail_count=1.
REQ-036 TIMEOUT=16, lane1 never ready -> done 17 cycles after valid, timeout=1, match=0, mismatch_mask=2'b10.
REQ-037 g_reset pulsed mid-COLLECT -> busy=0 next cycle, counters 0, no done; next operation completes normally.
REQ-038 fail_count=0xFFFF plus failing op -> stays 0xFFFF; clear coincident with REPORT -> op_count=0, fail_count=0, sticky_fail=0.
